// File: rtl/unit_sched_pkg.sv
// Shared definitions for the round-robin unit scheduler: state encoding and
// the modulo-wrap round-robin search used by the pick logic.
package unit_sched_pkg;

  localparam int MAX_UNITS = 64;
  localparam int RR_IDX_W  = 6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_result_t;

  // Scans last+1, last+2, ... with true modulo-n wrap; last < n, so one
  // conditional subtraction keeps every candidate inside 0..n-1.
  function automatic rr_result_t rr_next(input logic [MAX_UNITS-1:0] req,
                                         input logic [RR_IDX_W-1:0]  last,
                                         input int                   n);
    rr_result_t          res;
    logic [RR_IDX_W:0]   cand;
    res = '0;
    for (int k = 1; k <= MAX_UNITS; k++) begin
      cand = {1'b0, last} + (RR_IDX_W + 1)'(k);
      if (cand >= (RR_IDX_W + 1)'(n)) cand = cand - (RR_IDX_W + 1)'(n);
      if (k <= n && !res.found && req[cand[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/unit_rr_scheduler_rr_pick.sv
// Combinational round-robin pick: first set request after `last`, wrapping
// modulo NUM_UNITS (non-power-of-2 counts wrap correctly).
module rr_pick
  import unit_sched_pkg::*;
#(
  parameter int NUM_UNITS = 5
) (
  input  logic [NUM_UNITS-1:0]         req,
  input  logic [$clog2(NUM_UNITS)-1:0] last,
  output logic [$clog2(NUM_UNITS)-1:0] idx,
  output logic                         found
);

  localparam int IDX_W = $clog2(NUM_UNITS);

  rr_result_t res;

  always_comb begin
    res   = rr_next(MAX_UNITS'(req), RR_IDX_W'(last), NUM_UNITS);
    idx   = IDX_W'(res.idx);
    found = res.found;
  end

endmodule

// File: rtl/unit_rr_scheduler.sv
// Round-robin owner of the single active-unit slot: grants one requester at a
// time and holds it until done, request drop, or the hold budget runs out.
module unit_rr_scheduler
  import unit_sched_pkg::*;
#(
  parameter int NUM_UNITS = 5,
  parameter int MAX_HOLD  = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic [NUM_UNITS-1:0]         req,
  input  logic                         done,
  output logic [NUM_UNITS-1:0]         grant,
  output logic [$clog2(NUM_UNITS)-1:0] active_unit,
  output logic                         active_valid,
  output logic                         timeout
);

  localparam int IDX_W  = $clog2(NUM_UNITS);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_e               state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [NUM_UNITS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     active_unit_q, active_unit_d;
  logic                 active_valid_q, active_valid_d;
  logic                 timeout_q, timeout_d;

  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic                 drop_hit, budget_hit, release_now;

  rr_pick #(.NUM_UNITS(NUM_UNITS)) u_pick (
    .req   (req),
    .last  (last_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign drop_hit    = !req[active_unit_q];
  assign budget_hit  = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign release_now = done || drop_hit || budget_hit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= IDLE;
      hold_cnt_q     <= '0;
      last_q         <= IDX_W'(NUM_UNITS - 1);
      grant_q        <= '0;
      active_unit_q  <= '0;
      active_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      last_q         <= last_d;
      grant_q        <= grant_d;
      active_unit_q  <= active_unit_d;
      active_valid_q <= active_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    last_d     = last_q;
    unique case (state_q)
      IDLE: begin
        if (en && pick_found) begin
          state_d    = BUSY;
          hold_cnt_d = '0;
          last_d     = pick_idx;
        end
      end
      BUSY: begin
        if (release_now) state_d = IDLE;
        else             hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      end
    endcase
  end

  // Every release passes through IDLE, guaranteeing one grant-free cycle.
  always_comb begin
    grant_d        = grant_q;
    active_unit_d  = active_unit_q;
    active_valid_d = active_valid_q;
    timeout_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && pick_found) begin
          grant_d        = NUM_UNITS'(1) << pick_idx;
          active_unit_d  = pick_idx;
          active_valid_d = 1'b1;
        end
      end
      BUSY: begin
        if (release_now) begin
          grant_d        = '0;
          active_valid_d = 1'b0;
          timeout_d      = budget_hit && !done && !drop_hit;
        end
      end
    endcase
  end

  assign grant        = grant_q;
  assign active_unit  = active_unit_q;
  assign active_valid = active_valid_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_unit_rr_scheduler.sv
// Bench for unit_rr_scheduler: hand-derived vector table, explicit timeout
// sequences, and randomized traffic against a behavioural reference model.
module tb_unit_rr_scheduler;

  localparam int N  = 5;
  localparam int MH = 8;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rstn, en, done;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [IW-1:0] active_unit;
  logic          active_valid, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  unit_rr_scheduler #(.NUM_UNITS(N), .MAX_HOLD(MH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .req          (req),
    .done         (done),
    .grant        (grant),
    .active_unit  (active_unit),
    .active_valid (active_valid),
    .timeout      (timeout)
  );

  // Reference model: tracks owner and number of cycles the grant has been visible.
  bit m_busy, m_to;
  int m_au, m_held, m_last;

  task automatic model_step();
    if (!rstn) begin
      m_busy = 0; m_to = 0; m_au = 0; m_held = 0; m_last = N - 1;
    end else if (!m_busy) begin
      m_to = 0;
      if (en && req != '0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (req[c]) begin
            m_busy = 1; m_au = c; m_last = c; m_held = 1;
            break;
          end
        end
      end
    end else begin
      bit by_done, by_drop, by_budget;
      by_done   = done;
      by_drop   = !req[m_au];
      by_budget = (m_held == MH);
      if (by_done || by_drop || by_budget) begin
        m_busy = 0;
        m_to   = by_budget && !by_done && !by_drop;
      end else begin
        m_held++;
        m_to = 0;
      end
    end
  endtask

  function automatic logic [31:0] pack(logic [N-1:0] g, int au, logic v, logic t);
    logic [IW-1:0] a;
    a = IW'(au);
    return 32'({g, a, v, t});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [N-1:0] g, input int au,
                            input logic v, input logic t);
    check(name, pack(grant, int'(active_unit), active_valid, timeout), pack(g, au, v, t));
  endtask

  task automatic tick(input string tag);
    logic [N-1:0] mg;
    model_step();
    @(posedge clk);
    #1;
    mg = m_busy ? (N'(1) << m_au) : '0;
    expect_out({tag, "/model"}, mg, m_au, m_busy, m_to);
    check({tag, "/onehot0"}, 32'($onehot0(grant)), 32'd1);
    check({tag, "/grant_vs_valid"}, 32'(grant[active_unit]), 32'(active_valid));
  endtask

  typedef struct {
    logic         rstn, en, done;
    logic [N-1:0] req;
    logic [N-1:0] g;
    int           au;
    logic         v, t;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic e, logic [N-1:0] q, logic d,
                              logic [N-1:0] g, int au, logic v, logic t);
    vec_t x;
    x.rstn = r; x.en = e; x.req = q; x.done = d;
    x.g = g; x.au = au; x.v = v; x.t = t;
    return x;
  endfunction

  initial begin
    rstn = 1'b0; en = 1'b1; req = '0; done = 1'b0;

    // reset, then rotation 0,1,2,3,4,0,1 with one idle cycle between grants
    tbl.push_back(mk(0, 1, 5'b11111, 0, 5'b00000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 5'b11111, 0, 5'b00000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 0, 5'b00001, 0, 1, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 0, 5'b00001, 0, 1, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 1, 5'b00000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 0, 5'b00010, 1, 1, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 1, 5'b00000, 1, 0, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 0, 5'b00100, 2, 1, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 1, 5'b00000, 2, 0, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 0, 5'b01000, 3, 1, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 1, 5'b00000, 3, 0, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 0, 5'b10000, 4, 1, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 1, 5'b00000, 4, 0, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 0, 5'b00001, 0, 1, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 1, 5'b00000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 0, 5'b00010, 1, 1, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 1, 5'b00000, 1, 0, 0));
    // request drop of unit 3, then scan 4,0 picks unit 0
    tbl.push_back(mk(1, 1, 5'b01000, 0, 5'b01000, 3, 1, 0));
    tbl.push_back(mk(1, 1, 5'b01000, 0, 5'b01000, 3, 1, 0));
    tbl.push_back(mk(1, 1, 5'b01000, 0, 5'b01000, 3, 1, 0));
    tbl.push_back(mk(1, 1, 5'b00001, 0, 5'b00000, 3, 0, 0));
    tbl.push_back(mk(1, 1, 5'b01001, 0, 5'b00001, 0, 1, 0));
    tbl.push_back(mk(1, 1, 5'b01001, 1, 5'b00000, 0, 0, 0));
    // en low mid-grant, then reset mid-grant
    tbl.push_back(mk(1, 1, 5'b00010, 0, 5'b00010, 1, 1, 0));
    tbl.push_back(mk(1, 0, 5'b11111, 0, 5'b00010, 1, 1, 0));
    tbl.push_back(mk(1, 0, 5'b11111, 1, 5'b00000, 1, 0, 0));
    tbl.push_back(mk(1, 0, 5'b11111, 0, 5'b00000, 1, 0, 0));
    tbl.push_back(mk(1, 0, 5'b11111, 0, 5'b00000, 1, 0, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 0, 5'b00100, 2, 1, 0));
    tbl.push_back(mk(0, 1, 5'b11111, 0, 5'b00000, 0, 0, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 0, 5'b00001, 0, 1, 0));
    tbl.push_back(mk(1, 1, 5'b11111, 1, 5'b00000, 0, 0, 0));

    foreach (tbl[i]) begin
      rstn = tbl[i].rstn; en = tbl[i].en; req = tbl[i].req; done = tbl[i].done;
      tick("tbl");
      expect_out($sformatf("tbl_row%0d", i), tbl[i].g, tbl[i].au, tbl[i].v, tbl[i].t);
    end

    // hold budget expiry: 8 granted cycles, timeout pulse in the idle cycle, re-grant
    rstn = 1'b0; en = 1'b1; req = '0; done = 1'b0;
    tick("to_rst");
    rstn = 1'b1; req = 5'b00100;
    tick("to");
    expect_out("to_grant0", 5'b00100, 2, 1, 0);
    for (int i = 1; i < MH; i++) begin
      tick("to");
      expect_out($sformatf("to_hold%0d", i), 5'b00100, 2, 1, 0);
    end
    tick("to");
    expect_out("to_pulse", 5'b00000, 2, 0, 1);
    tick("to");
    expect_out("to_regrant", 5'b00100, 2, 1, 0);

    // done coincident with the last budget cycle is a normal completion
    for (int i = 1; i < MH; i++) begin
      tick("dc");
      expect_out($sformatf("dc_hold%0d", i), 5'b00100, 2, 1, 0);
    end
    done = 1'b1;
    tick("dc");
    expect_out("dc_release", 5'b00000, 2, 0, 0);
    done = 1'b0; req = '0;
    tick("dc");
    expect_out("dc_idle", 5'b00000, 2, 0, 0);

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      rstn = ($urandom_range(0, 99) != 0);
      en   = ($urandom_range(0, 9) != 0);
      done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unit_rr_scheduler.md
Name: unit_rr_scheduler

Overview:
- Round-robin scheduler that shares one active-unit slot among NUM_UNITS requesters.
- Drives the `active_unit` index (width $clog2(NUM_UNITS)) consumed by the des-style unit datapath.
- Holds each grant until the unit signals done, drops its request, or exceeds a hold budget.
- Sits between the requesting agents and the unit-select input of the datapath.

Parameters:
- NUM_UNITS, 5, number of requesters; legal range 2..64; non-power-of-2 values are legal.
- MAX_HOLD, 8, maximum cycles a grant may be held; legal range 2..255.
- IDX_W, $clog2(NUM_UNITS), index width; derived, never overridden.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- en  in  1  when low, no new grants are issued; a current grant runs to completion.
- req  in  NUM_UNITS  per-unit request levels.
- done  in  1  active unit finished; sampled only in BUSY.
- grant  out  NUM_UNITS  one-hot grant; all zero when idle.
- active_unit  out  IDX_W  index of the granted unit; holds its last value when idle.
- active_valid  out  1  high while a grant is held.
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold budget.

Behaviour:
- Reset (rstn low at an edge):
  - Outputs: grant=0, active_unit=0, active_valid=0, timeout=0.
  - Internal: state=IDLE, hold_cnt=0, last=NUM_UNITS-1, so unit 0 has first priority.
  - Reset mid-grant aborts the grant immediately, with no timeout pulse.
- States: IDLE, BUSY. All outputs are registered.
- IDLE:
  - If en=1 and req!=0, pick the first set req[i] scanning i = last+1, last+2, … modulo NUM_UNITS.
    - Wrap is true modulo, not power-of-2 masking: with NUM_UNITS=5, the scan order after unit 4 is 0,1,2,3,4.
  - Next edge: grant[i]=1, active_unit=i, active_valid=1, last=i, hold_cnt=0, state→BUSY.
  - Latency from req seen to grant visible: 1 cycle.
  - If en=0 or req=0, stay in IDLE.
- BUSY: release at the next edge if any of these holds:
  - (a) done=1;
  - (b) req[active_unit]=0;
  - (c) hold_cnt==MAX_HOLD-1.
- On release:
  - grant=0, active_valid=0, state→IDLE; active_unit keeps its value.
  - timeout=1 for exactly one cycle only when (c) is true and neither (a) nor (b) is.
- Otherwise in BUSY, hold_cnt increments; its width is $clog2(MAX_HOLD+1) and it cannot wrap.
- Release always leaves exactly one IDLE cycle (grant=0) before the next grant.
  - This gives the datapath a clean switch boundary; maximum back-to-back utilisation is MAX_HOLD/(MAX_HOLD+1).
- Simultaneous done and timeout condition: treated as a normal completion, no timeout pulse.
- en falling during BUSY has no effect on the current grant; no new grant is issued while en=0.
- Requests arriving while BUSY are ignored until IDLE and considered in the next arbitration.
- The granted unit re-requesting immediately gets lowest priority; it is re-granted only if no other unit requests.
- Invariants:
  - grant is always zero or one-hot.
  - grant[active_unit]==active_valid.
  - active_unit < NUM_UNITS always.

Decomposition:
- Shared package unit_sched_pkg:
  - state encoding constants (IDLE=0, BUSY=1);
  - a function rr_next(req, last, n) returning the winning index and a found flag.
- One natural sub-module, rr_pick: combinational rotate-and-priority-encode over NUM_UNITS with modulo wrap; reusable by other arbiters.
- The FSM, hold counter and output registers stay in unit_rr_scheduler.

Test Plan (NUM_UNITS=5, MAX_HOLD=8):
- Reset: hold rstn=0 for 2 cycles with req=5'b11111 → grant=0, active_valid=0, active_unit=0. Release rstn → one cycle later grant=5'b00001, active_unit=0.
- Rotation/wrap: req=5'b11111 held, done pulsed 2 cycles after each grant → grant order 0,1,2,3,4,0,1 with active_unit matching, and exactly one idle cycle between grants.
- Timeout: req=5'b00100 held, done=0 → grant=5'b00100 for 8 cycles, then a timeout pulse of 1 cycle with grant=0, then re-grant of unit 2 after one idle cycle.
- Done coincident with the 8th hold cycle → release with timeout=0.
- Request drop: grant unit 3, deassert req[3] after 3 cycles → grant=0 on the next edge, no timeout. With req=5'b01001 the next grant is unit 0 (scan 4,0).
- Enable/reset mid-grant: en=0 while unit 1 is granted → grant continues until done, then no grant while en=0 even with req=5'b11111. rstn=0 during BUSY → grant=0 on the next edge, timeout=0, and priority restarts at unit 0.
